// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for a single-port memory: M1 (LSU) has fixed priority, M0 (fetch) has a starvation guard.
// One transaction outstanding; grant is combinational in IDLE; optional slave timeout under `ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int STARVE_MAX  = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m0_req,
    input  logic [AW-1:0]   m0_addr,
    output logic            m0_gnt,
    output logic            m0_rvalid,
    output logic [DW-1:0]   m0_rdata,
    output logic            m0_err,
    input  logic            m1_req,
    input  logic            m1_we,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_wstrb,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    output logic [DW-1:0]   m1_rdata,
    output logic            m1_err,
    output logic            s_req,
    output logic            s_we,
    output logic [AW-1:0]   s_addr,
    output logic [DW-1:0]   s_wdata,
    output logic [DW/8-1:0] s_wstrb,
    input  logic            s_rvalid,
    input  logic [DW-1:0]   s_rdata
);

    if (STARVE_MAX < 1 || STARVE_MAX > 15 || TIMEOUT_CYC < 2) begin : g_param_check
        $error("mem_bus_arbiter: STARVE_MAX must be 1..15 and TIMEOUT_CYC at least 2");
    end

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t     state;
    logic       owner;
    logic [3:0] starve_cnt;

    logic m0_starved;
    logic m1_win;
    logic m0_win;
    logic busy;
    logic tmo;
    logic done;

    assign m0_starved = m0_req && (starve_cnt >= 4'(STARVE_MAX));
    assign m1_win     = !rst && (state == IDLE) && m1_req && !m0_starved;
    assign m0_win     = !rst && (state == IDLE) && m0_req && !m1_win;
    assign busy       = !rst && (state == BUSY);

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;

    // A real response in the expiry cycle wins over the timeout.
    assign tmo = busy && !s_rvalid && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`else
    assign tmo = 1'b0;
`endif

    assign done = busy && (s_rvalid || tmo);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            starve_cnt <= 4'd0;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (m1_win || m0_win) begin
                        state <= BUSY;
                        owner <= m1_win;
`ifdef ARB_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end
                    if (!m0_req || m0_win)
                        starve_cnt <= 4'd0;
                    else if (m1_win && starve_cnt != 4'hF)
                        starve_cnt <= starve_cnt + 4'd1;
                end
                BUSY: begin
                    if (done)
                        state <= IDLE;
`ifdef ARB_TIMEOUT_EN
                    else
                        tmo_cnt <= tmo_cnt + TW'(1);
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m0_gnt = m0_win;
    assign m1_gnt = m1_win;
    assign s_req  = m0_win || m1_win;

    // Fetches are always reads, so M0 contributes only its address.
    assign s_we    = m1_win && m1_we;
    assign s_addr  = m1_win ? m1_addr : (m0_win ? m0_addr : '0);
    assign s_wdata = m1_win ? m1_wdata : '0;
    assign s_wstrb = m1_win ? m1_wstrb : '0;

    assign m0_rvalid = done && !owner;
    assign m1_rvalid = done && owner;
    assign m0_rdata  = (m0_rvalid && s_rvalid) ? s_rdata : '0;
    assign m1_rdata  = (m1_rvalid && s_rvalid) ? s_rdata : '0;
    assign m0_err    = m0_rvalid && tmo;
    assign m1_err    = m1_rvalid && tmo;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed-vector bench for mem_bus_arbiter; inputs change on the falling edge, outputs sampled 1 ns later.
module tb_mem_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            m0_req;
    logic [AW-1:0]   m0_addr;
    logic            m0_gnt, m0_rvalid, m0_err;
    logic [DW-1:0]   m0_rdata;
    logic            m1_req, m1_we;
    logic [AW-1:0]   m1_addr;
    logic [DW-1:0]   m1_wdata;
    logic [DW/8-1:0] m1_wstrb;
    logic            m1_gnt, m1_rvalid, m1_err;
    logic [DW-1:0]   m1_rdata;
    logic            s_req, s_we;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic [DW/8-1:0] s_wstrb;
    logic            s_rvalid;
    logic [DW-1:0]   s_rdata;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_rvalid(s_rvalid), .s_rdata(s_rdata)
    );

    task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Falling edge for driving, then settle before sampling.
    task automatic next_cyc();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        logic exp_m1;
        logic seen_rvalid;

        rst = 1'b1; m0_req = 1'b1; m0_addr = 32'h20;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h40; m1_wdata = '0; m1_wstrb = '0;
        s_rvalid = 1'b0; s_rdata = '0;

        // Reset with both masters requesting: everything held at zero.
        for (int i = 0; i < 3; i++) begin
            next_cyc(); settle();
            check_vec("rst_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
            check_vec("rst_sreq", {31'd0, s_req}, 32'd0);
            check_vec("rst_saddr", s_addr, 32'd0);
            check_vec("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        end
        next_cyc(); rst = 1'b0; settle();
        check_vec("first_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd2);
        check_vec("first_saddr", s_addr, 32'h40);
        next_cyc(); m0_req = 1'b0; m1_req = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h5; settle();
        check_vec("first_rsp", {30'd0, m1_rvalid, m0_rvalid}, 32'd2);
        check_vec("first_rdata", m1_rdata, 32'h5);

        // Single fetch with stale LSU write data on the bus inputs.
        next_cyc(); s_rvalid = 1'b0; s_rdata = '0;
        m0_req = 1'b1; m0_addr = 32'h10; m1_wdata = 32'hFFFF_FFFF; m1_wstrb = 4'hF; m1_we = 1'b1;
        settle();
        check_vec("fetch_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
        check_vec("fetch_sreq", {31'd0, s_req}, 32'd1);
        check_vec("fetch_saddr", s_addr, 32'h10);
        check_vec("fetch_swe", {31'd0, s_we}, 32'd0);
        check_vec("fetch_swdata", s_wdata, 32'd0);
        check_vec("fetch_swstrb", {28'd0, s_wstrb}, 32'd0);
        next_cyc(); m0_req = 1'b0; settle();
        check_vec("fetch_busy_sreq", {31'd0, s_req}, 32'd0);
        check_vec("fetch_wait_rvalid", {31'd0, m0_rvalid}, 32'd0);
        next_cyc(); s_rvalid = 1'b1; s_rdata = 32'h93; settle();
        check_vec("fetch_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd1);
        check_vec("fetch_rdata", m0_rdata, 32'h93);
        check_vec("fetch_m1_rdata", m1_rdata, 32'd0);
        check_vec("fetch_err", {31'd0, m0_err}, 32'd0);

        // Continuous contention: M1 x4, then starved M0, then M1 again.
        m1_we = 1'b0; m1_wdata = '0; m1_wstrb = '0;
        for (int i = 0; i < 6; i++) begin
            next_cyc(); s_rvalid = 1'b0; s_rdata = '0;
            m0_req = 1'b1; m0_addr = 32'h1000; m1_req = 1'b1; m1_addr = 32'h2000;
            settle();
            exp_m1 = (i != 4);
            check_vec($sformatf("cont_gnt%0d", i), {30'd0, m1_gnt, m0_gnt}, exp_m1 ? 32'd2 : 32'd1);
            check_vec($sformatf("cont_addr%0d", i), s_addr, exp_m1 ? 32'h2000 : 32'h1000);
            next_cyc(); s_rvalid = 1'b1; s_rdata = 32'hA0 + i; settle();
            check_vec($sformatf("cont_rsp%0d", i), {30'd0, m1_rvalid, m0_rvalid}, exp_m1 ? 32'd2 : 32'd1);
        end
        next_cyc(); s_rvalid = 1'b0; m0_req = 1'b0; m1_req = 1'b0; settle();
        check_vec("cont_release", {30'd0, m1_gnt, m0_gnt}, 32'd0);

        // LSU partial write.
        next_cyc(); m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h100;
        m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'h3; settle();
        check_vec("wr_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd2);
        check_vec("wr_swe", {30'd0, s_req, s_we}, 32'd3);
        check_vec("wr_saddr", s_addr, 32'h100);
        check_vec("wr_swdata", s_wdata, 32'hDEAD_BEEF);
        check_vec("wr_swstrb", {28'd0, s_wstrb}, 32'h3);
        next_cyc(); m1_req = 1'b0; m1_we = 1'b0; settle();
        check_vec("wr_wait", {31'd0, m1_rvalid}, 32'd0);
        next_cyc(); s_rvalid = 1'b1; settle();
        check_vec("wr_ack", {30'd0, m1_rvalid, m0_rvalid}, 32'd2);

        // Reset while BUSY, then a late response that must be dropped.
        next_cyc(); s_rvalid = 1'b0; m0_req = 1'b1; m0_addr = 32'h30; settle();
        check_vec("rstb_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
        next_cyc(); m0_req = 1'b0; rst = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h66; settle();
        check_vec("rstb_forced", {29'd0, m0_rvalid, m0_gnt, s_req}, 32'd0);
        next_cyc(); rst = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h77; settle();
        check_vec("rstb_late_rsp", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        check_vec("rstb_late_rdata", m0_rdata, 32'd0);
        next_cyc(); s_rvalid = 1'b0; m0_req = 1'b1; m0_addr = 32'h34; settle();
        check_vec("rstb_regnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
        check_vec("rstb_readdr", s_addr, 32'h34);
        next_cyc(); m0_req = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h11; settle();
        check_vec("rstb_rsp", m0_rdata, 32'h11);

        // Slave never answers.
        next_cyc(); s_rvalid = 1'b0; s_rdata = 32'hABCD; m1_req = 1'b1; m1_addr = 32'h200; settle();
        check_vec("tmo_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd2);
`ifdef ARB_TIMEOUT_EN
        seen_rvalid = 1'b0;
        for (int k = 1; k < 8; k++) begin
            next_cyc(); m1_req = 1'b0; settle();
            seen_rvalid = seen_rvalid | m1_rvalid | m0_rvalid;
        end
        check_vec("tmo_early", {31'd0, seen_rvalid}, 32'd0);
        next_cyc(); settle();
        check_vec("tmo_rvalid", {29'd0, m1_err, m1_rvalid, m0_rvalid}, 32'd6);
        check_vec("tmo_rdata", m1_rdata, 32'd0);
        next_cyc(); m0_req = 1'b1; m0_addr = 32'h50; settle();
        check_vec("tmo_idle_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
        next_cyc(); m0_req = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h9; settle();
        check_vec("tmo_next_rsp", {30'd0, m0_err, m0_rvalid}, 32'd1);
`else
        seen_rvalid = 1'b0;
        for (int k = 0; k < 105; k++) begin
            next_cyc(); m1_req = 1'b0; settle();
            seen_rvalid = seen_rvalid | m1_rvalid | m0_rvalid;
        end
        check_vec("hang_no_rvalid", {31'd0, seen_rvalid}, 32'd0);
        next_cyc(); m0_req = 1'b1; m0_addr = 32'h50; settle();
        check_vec("hang_still_busy", {30'd0, m1_gnt, m0_gnt}, 32'd0);
        check_vec("hang_err_tied", {30'd0, m1_err, m0_err}, 32'd0);
        next_cyc(); s_rvalid = 1'b1; s_rdata = 32'h9; settle();
        check_vec("hang_rsp", {29'd0, m1_err, m1_rvalid, m0_rvalid}, 32'd2);
        check_vec("hang_rdata", m1_rdata, 32'h9);
        next_cyc(); s_rvalid = 1'b0; settle();
        check_vec("hang_then_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
`endif

        next_cyc(); m0_req = 1'b0; m1_req = 1'b0; s_rvalid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
